maxnet_engine: RTL

Parametrised N-channel Maxnet winner-take-all engine, the successor to the fixed 4-neuron Maxnet datapath. It loads N signed fixed-point activations and runs mutual-inhibition iterations, a_i ← max(0, a_i − ε·Σ_{j≠i} a_j), until at most one channel stays nonzero or an iteration limit is hit. It then reports the winning index, its value and status flags. It time-multiplexes one multiplier across channels rather than instantiating one processing unit per neuron.

---
 rtl/maxnet_engine.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/maxnet_engine.sv
// maxnet_engine: N-channel Maxnet winner-take-all engine.
// Loads N signed activations, clamps negatives to zero, then runs
// mutual-inhibition iterations with one shared multiplier until at
// most one channel is nonzero or MAX_ITER iterations have run.
// Optional build macro: MAXNET_ROUND_EN selects round-half-up on the
// inhibition shift (requires FRAC >= 1); otherwise the shift truncates.
module maxnet_engine #(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int FRAC     = 16,
    parameter int MAX_ITER = 255,
    localparam int IW      = $clog2(MAX_ITER + 1),
    localparam int NW      = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N*W-1:0]    a_in,
    input  logic [W-1:0]      epsilon,
    output logic              busy,
    output logic              done,
    output logic [NW-1:0]     winner,
    output logic [W-1:0]      win_value,
    output logic [IW-1:0]     iter_count,
    output logic              timeout,
    output logic              none
);

    // Sum of N non-negative W-bit values cannot overflow SW bits.
    localparam int SW = W + $clog2(N);
    localparam int PW = W + SW;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUM,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]  a_reg [N];
    logic [W-1:0]  eps_r;
    logic [SW-1:0] acc;
    logic [NW-1:0] idx;
    logic [CW-1:0] nz_cnt;
    logic [W-1:0]  max_val;
    logic [NW-1:0] max_idx;

    logic          last_idx;
    logic [W-1:0]  cur_a;
    logic [SW-1:0] others;
    logic [PW-1:0] prod;
    logic [PW-1:0] inh;
    logic [W-1:0]  new_a;

    // Scale the epsilon product back to activation units.
    function automatic logic [PW-1:0] inh_shift(input logic [PW-1:0] p);
`ifdef MAXNET_ROUND_EN
        return (p + (PW'(1) << (FRAC - 1))) >> FRAC;
`else
        return p >> FRAC;
`endif
    endfunction

    // Shared inhibition datapath for the channel selected by idx.
    always_comb begin
        last_idx = (idx == NW'(N - 1));
        cur_a    = a_reg[idx];
        others   = acc - SW'(cur_a);
        prod     = PW'(eps_r) * PW'(others);
        inh      = inh_shift(prod);
        new_a    = (inh >= PW'(cur_a)) ? '0 : (cur_a - inh[W-1:0]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; the iteration limit is tested against the
    // pre-increment count so CHECK decides on the value it produces.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SUM;
            S_SUM:    if (last_idx) state_nxt = S_UPDATE;
            S_UPDATE: if (last_idx) state_nxt = S_CHECK;
            S_CHECK:  if (nz_cnt <= CW'(1) || iter_count == IW'(MAX_ITER - 1))
                          state_nxt = S_DONE;
                      else
                          state_nxt = S_SUM;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath, run bookkeeping and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) a_reg[i] <= '0;
            eps_r      <= '0;
            acc        <= '0;
            idx        <= '0;
            nz_cnt     <= '0;
            max_val    <= '0;
            max_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            winner     <= '0;
            win_value  <= '0;
            iter_count <= '0;
            timeout    <= 1'b0;
            none       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        eps_r <= epsilon;
                        for (int i = 0; i < N; i++)
                            a_reg[i] <= a_in[i*W + W - 1] ? '0 : a_in[i*W +: W];
                        iter_count <= '0;
                        acc        <= '0;
                        idx        <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_SUM: begin
                    acc <= acc + SW'(cur_a);
                    idx <= last_idx ? '0 : idx + 1'b1;
                    if (last_idx) begin
                        nz_cnt  <= '0;
                        max_val <= '0;
                        max_idx <= '0;
                    end
                end
                S_UPDATE: begin
                    a_reg[idx] <= new_a;
                    if (new_a != '0) nz_cnt <= nz_cnt + 1'b1;
                    // Strict compare keeps the lowest index on ties.
                    if (new_a > max_val) begin
                        max_val <= new_a;
                        max_idx <= idx;
                    end
                    idx <= last_idx ? '0 : idx + 1'b1;
                end
                S_CHECK: begin
                    iter_count <= iter_count + 1'b1;
                    acc        <= '0;
                end
                S_DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    none      <= (nz_cnt == '0);
                    timeout   <= (nz_cnt > CW'(1));
                    winner    <= (nz_cnt == '0) ? '0 : max_idx;
                    win_value <= (nz_cnt == '0) ? '0 : max_val;
                end
                default: ;
            endcase
        end
    end

endmodule
